// File: rtl/score_keeper.sv
// Score keeper and match sequencer: counts toggle-encoded goals, sequences
// serve/play/pause/over, and drives the ball controller's serve and game-over inputs.
module score_keeper #(
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       blue_score_up,
    input  logic       red_score_up,
    output logic       game_initiated,
    output logic       game_over,
    output logic [3:0] blue_score,
    output logic [3:0] red_score,
    output logic [1:0] winner
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = $clog2(PAUSE_CYCLES + 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_PAUSE,
        S_OVER
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_blue_prev;
    logic               r_red_prev;
    logic               r_start_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SCORE_W-1:0] r_blue;
    logic [SCORE_W-1:0] r_red;
    logic [SCORE_W-1:0] w_blue_nxt;
    logic [SCORE_W-1:0] w_red_nxt;
    logic [1:0]         r_winner;
    logic [1:0]         w_winner_nxt;
    logic               r_game_initiated;
    logic               r_game_over;

    logic               w_ev_b;
    logic               w_ev_r;
    logic [SCORE_W-1:0] w_blue_inc;
    logic [SCORE_W-1:0] w_red_inc;
    logic               w_win_b;
    logic               w_win_r;
    logic               w_start_rise;

    // Each transition of a toggle line is one goal.
    assign w_ev_b       = blue_score_up ^ r_blue_prev;
    assign w_ev_r       = red_score_up ^ r_red_prev;
    assign w_blue_inc   = r_blue + SCORE_W'(w_ev_b);
    assign w_red_inc    = r_red + SCORE_W'(w_ev_r);
    assign w_win_b      = (w_blue_inc == WIN_VAL);
    assign w_win_r      = (w_red_inc == WIN_VAL);
    assign w_start_rise = start & ~r_start_prev;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_blue_nxt   = r_blue;
        w_red_nxt    = r_red;
        w_winner_nxt = r_winner;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE, S_PLAY: begin
                w_blue_nxt = w_blue_inc;
                w_red_nxt  = w_red_inc;
                if (w_win_b || w_win_r) begin
                    w_state_nxt  = S_OVER;
                    w_winner_nxt = {w_win_r, w_win_b};
                end else if (w_ev_b || w_ev_r) begin
                    w_state_nxt = S_PAUSE;
                    w_cnt_nxt   = '0;
                end else if (r_state == S_SERVE) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PAUSE: begin
                // Ball is dead: goals ignored until the re-serve.
                if (r_cnt == PAUSE_LAST) begin
                    w_state_nxt = S_SERVE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt  = S_SERVE;
                    w_blue_nxt   = '0;
                    w_red_nxt    = '0;
                    w_winner_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Prev copies track inputs even in reset so no phantom event follows it.
    always_ff @(posedge clk) begin
        r_blue_prev  <= blue_score_up;
        r_red_prev   <= red_score_up;
        r_start_prev <= start;
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_blue           <= '0;
            r_red            <= '0;
            r_winner         <= 2'b00;
            r_game_initiated <= 1'b0;
            r_game_over      <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_blue           <= w_blue_nxt;
            r_red            <= w_red_nxt;
            r_winner         <= w_winner_nxt;
            r_game_initiated <= (w_state_nxt == S_SERVE);
            r_game_over      <= (w_state_nxt == S_OVER);
        end
    end

    assign game_initiated = r_game_initiated;
    assign game_over      = r_game_over;
    assign blue_score     = r_blue;
    assign red_score      = r_red;
    assign winner         = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed match scenarios plus a random
// run compared cycle by cycle against a goal/pause bookkeeping model.
module tb_score_keeper;

    localparam int WIN = 3;
    localparam int PC  = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       bup   = 1'b1;
    logic       rup   = 1'b0;
    logic       gi;
    logic       go;
    logic [3:0] bs;
    logic [3:0] rs;
    logic [1:0] win;

    int n_pass  = 0;
    int n_total = 0;

    score_keeper #(
        .WIN_SCORE   (WIN),
        .PAUSE_CYCLES(PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .blue_score_up (bup),
        .red_score_up  (rup),
        .game_initiated(gi),
        .game_over     (go),
        .blue_score    (bs),
        .red_score     (rs),
        .winner        (win)
    );

    always #5 clk = ~clk;

    // Reference model: a match is idle, live, cooling down for a number of
    // cycles after a goal, or finished.
    int m_blue = 0, m_red = 0, m_win = 0, m_pause = 0;
    bit m_gi = 0, m_go = 0, m_idle = 1, m_live = 0, m_over = 0;
    bit m_bprev = 0, m_rprev = 0, m_sprev = 0;

    task automatic model_edge();
        bit eb, er, sp;
        eb = bup ^ m_bprev;
        er = rup ^ m_rprev;
        sp = m_sprev;
        m_bprev = bup;
        m_rprev = rup;
        m_sprev = start;
        m_gi = 1'b0;
        if (rst) begin
            m_blue = 0; m_red = 0; m_win = 0; m_pause = 0;
            m_go = 0; m_idle = 1; m_live = 0; m_over = 0;
        end else if (m_idle) begin
            if (start) begin
                m_idle = 0; m_live = 1; m_gi = 1;
            end
        end else if (m_over) begin
            if (start && !sp) begin
                m_blue = 0; m_red = 0; m_win = 0;
                m_over = 0; m_go = 0; m_live = 1; m_gi = 1;
            end
        end else if (m_pause > 0) begin
            m_pause = m_pause - 1;
            if (m_pause == 0) begin
                m_live = 1; m_gi = 1;
            end
        end else if (m_live) begin
            m_blue = m_blue + int'(eb);
            m_red  = m_red + int'(er);
            if (m_blue == WIN || m_red == WIN) begin
                m_over = 1; m_go = 1; m_live = 0;
                m_win = (m_red == WIN ? 2 : 0) + (m_blue == WIN ? 1 : 0);
            end else if (eb || er) begin
                m_live = 0;
                m_pause = PC + 1;
            end
        end
    endtask

    always @(posedge clk) model_edge();

    function automatic logic [11:0] obs();
        return {gi, go, bs, rs, win};
    endfunction

    function automatic logic [11:0] exp_model();
        return {m_gi, m_go, 4'(m_blue), 4'(m_red), 2'(m_win)};
    endfunction

    task automatic goal(input bit b, input bit r);
        if (b) bup = ~bup;
        if (r) rup = ~rup;
        @(negedge clk);
    endtask

    task automatic wait_gi(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (gi === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bup = 1'b1; rup = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (obs() !== 12'h000) $display("FAIL reset_idle[%0d]: got %h want 000", i, obs());
            else n_pass++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (obs() !== 12'h800) $display("FAIL serve_pulse: got %h want 800", obs());
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (obs() !== 12'h000) $display("FAIL serve_one_cycle: got %h want 000", obs());
        else n_pass++;
    endtask

    task automatic test_single_goal();
        int n;
        goal(1'b0, 1'b1);
        n_total++;
        if (obs() !== 12'h004) $display("FAIL red_goal: got %h want 004", obs());
        else n_pass++;
        wait_gi(30, n);
        n_total++;
        if (n != PC + 1) $display("FAIL reserve_gap: got %0d want %0d", n, PC + 1);
        else n_pass++;
        n_total++;
        if (obs() !== 12'h804) $display("FAIL reserve_state: got %h want 804", obs());
        else n_pass++;
    endtask

    task automatic test_win();
        int n;
        logic [11:0] want;
        @(negedge clk);
        for (int g = 1; g <= 3; g++) begin
            goal(1'b1, 1'b0);
            if (g < 3) begin
                want = {1'b0, 1'b0, 4'(g), 4'd1, 2'b00};
                n_total++;
                if (obs() !== want) $display("FAIL blue_goal[%0d]: got %h want %h", g, obs(), want);
                else n_pass++;
                wait_gi(30, n);
                n_total++;
                if (n != PC + 1) $display("FAIL win_gap[%0d]: got %0d want %0d", g, n, PC + 1);
                else n_pass++;
                @(negedge clk);
            end
        end
        want = {1'b0, 1'b1, 4'd3, 4'd1, 2'b01};
        n_total++;
        if (obs() !== want) $display("FAIL blue_win: got %h want %h", obs(), want);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            goal(1'b1, 1'b1);
            n_total++;
            if (obs() !== want) $display("FAIL over_hold[%0d]: got %h want %h", i, obs(), want);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        int n;
        logic [11:0] want;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (obs() !== 12'h800) $display("FAIL restart_serve: got %h want 800", obs());
        else n_pass++;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            goal(g % 2 == 0, g % 2 == 1);
            wait_gi(30, n);
            n_total++;
            if (n != PC + 1) $display("FAIL sim_gap[%0d]: got %0d want %0d", g, n, PC + 1);
            else n_pass++;
            @(negedge clk);
        end
        goal(1'b1, 1'b1);
        want = {1'b0, 1'b1, 4'd3, 4'd3, 2'b11};
        n_total++;
        if (obs() !== want) $display("FAIL draw: got %h want %h", obs(), want);
        else n_pass++;
    endtask

    task automatic test_ignored();
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            goal(1'b1, 1'b1);
            n_total++;
            if (obs() !== 12'h000) $display("FAIL idle_ignore[%0d]: got %h want 000", i, obs());
            else n_pass++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        goal(1'b1, 1'b0);
        n_total++;
        if (obs() !== 12'h040) $display("FAIL ign_goal: got %h want 040", obs());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            goal(1'b0, 1'b1);
            n_total++;
            if (obs() !== 12'h040) $display("FAIL pause_ignore[%0d]: got %h want 040", i, obs());
            else n_pass++;
        end
        wait_gi(30, n);
        n_total++;
        if (n != PC + 1 - 4) $display("FAIL pause_len: got %0d want %0d", n, PC + 1 - 4);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (obs() !== 12'h040) $display("FAIL no_spurious[%0d]: got %h want 040", i, obs());
            else n_pass++;
        end
    endtask

    task automatic test_midmatch_reset();
        int n;
        logic [11:0] want;
        goal(1'b1, 1'b0);
        wait_gi(30, n);
        @(negedge clk);
        goal(1'b0, 1'b1);
        n_total++;
        if (obs() !== 12'h084) $display("FAIL score_2_1: got %h want 084", obs());
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if (obs() !== 12'h000) $display("FAIL mid_reset: got %h want 000", obs());
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs() !== 12'h800) $display("FAIL level_start: got %h want 800", obs());
        else n_pass++;
        @(negedge clk);
        for (int g = 1; g <= 3; g++) begin
            goal(1'b1, 1'b0);
            if (g < 3) begin
                wait_gi(30, n);
                @(negedge clk);
            end
        end
        want = {1'b0, 1'b1, 4'd3, 4'd0, 2'b01};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (obs() !== want) $display("FAIL held_start[%0d]: got %h want %h", i, obs(), want);
            else n_pass++;
        end
        start = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs() !== want) $display("FAIL start_low: got %h want %h", obs(), want);
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (obs() !== 12'h800) $display("FAIL rematch: got %h want 800", obs());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) bup = ~bup;
            if ($urandom_range(0, 5) == 0) rup = ~rup;
            @(negedge clk);
            n_total++;
            if (obs() !== exp_model())
                $display("FAIL random[%0d]: got %h want %h", i, obs(), exp_model());
            else n_pass++;
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_goal();
        test_win();
        test_simultaneous();
        test_ignored();
        test_midmatch_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
